qconv_threshold_pack: RTL and testbench

- Output stage directly downstream of the kn2row quantized convolution core.
- Consumes UNROLL signed accumulators per beat from the core's WRITE_OUTPUT phase and applies per-channel 3-level thresholds to produce 2-bit activations.
- Packs results into bit-plane words (QUANTIZED_PACKED layout) for the next layer's READ_INPUT.

---
 rtl/qconv_pkg.sv | 26 ++
 rtl/qconv_threshold_lane.sv | 46 ++++
 rtl/qconv_threshold_pack.sv | 113 +++++++++++
 tb/tb_qconv_threshold_pack.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qconv_pkg.sv
// qconv_pkg: shared constants for the kn2row quantized-conv output stage.
// Holds the datapath geometry, the threshold-word field layout and the
// threshold flag encodings used by the table lanes and by software.
package qconv_pkg;

  localparam int UNROLL = 8;                    // channels per input beat
  localparam int ACC_W  = 16;                   // accumulator / threshold width
  localparam int PACK_W = 32;                   // channels per bit-plane word
  localparam int OC_MAX = 1024;                 // max output channels
  localparam int GRP_W  = 7;                    // log2(OC_MAX/UNROLL)
  localparam int LANE_W = $clog2(UNROLL);       // lane bits of a channel index
  localparam int DEPTH  = OC_MAX / UNROLL;      // table rows per lane
  localparam int BEATS  = PACK_W / UNROLL;      // beats per packed word
  localparam int CNT_W  = $clog2(BEATS);
  localparam int TH_W   = 4 * ACC_W;            // {flag, th2, th1, th0}

  // Field offsets inside one threshold word.
  localparam int TH0_LSB  = 0;
  localparam int TH1_LSB  = ACC_W;
  localparam int TH2_LSB  = 2 * ACC_W;
  localparam int FLAG_LSB = 3 * ACC_W;

  localparam logic signed [ACC_W-1:0] TH_FLAG_INC = 1;
  localparam logic signed [ACC_W-1:0] TH_FLAG_DEC = -1;

endpackage

// File: rtl/qconv_threshold_lane.sv
// qconv_threshold_lane: one lane's threshold table plus its 3-level quantizer.
// Ports:
//   clk            clock
//   wr_en/wr_grp/wr_data  table write (row = channel group)
//   rd_en/rd_grp   synchronous table read; the row register holds when rd_en=0
//   x              accumulator aligned with the registered row
//   q              2-bit activation derived from x and the registered row
module qconv_threshold_lane
  import qconv_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [GRP_W-1:0]  wr_grp,
  input  logic [TH_W-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [GRP_W-1:0]  rd_grp,
  input  logic [ACC_W-1:0]  x,
  output logic [1:0]        q
);

  logic [TH_W-1:0] mem [DEPTH];
  logic [TH_W-1:0] row;

  // Read-before-write: a same-cycle write and read of one row returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_grp] <= wr_data;
    if (rd_en) row <= mem[rd_grp];
  end

  logic signed [ACC_W-1:0] xs, th0, th1, th2, flag;
  logic [1:0] n_ge, n_le;

  always_comb begin
    xs   = $signed(x);
    th0  = $signed(row[TH0_LSB  +: ACC_W]);
    th1  = $signed(row[TH1_LSB  +: ACC_W]);
    th2  = $signed(row[TH2_LSB  +: ACC_W]);
    flag = $signed(row[FLAG_LSB +: ACC_W]);
    n_ge = 2'(xs >= th0) + 2'(xs >= th1) + 2'(xs >= th2);
    n_le = 2'(xs <= th0) + 2'(xs <= th1) + 2'(xs <= th2);
    if (flag == TH_FLAG_INC)      q = n_ge;
    else if (flag == TH_FLAG_DEC) q = n_le;
    else                          q = th0[1:0];   // constant channel
  end

endmodule

// File: rtl/qconv_threshold_pack.sv
// qconv_threshold_pack: thresholds UNROLL accumulators per beat into 2-bit
// activations and packs them into {plane1, plane0} bit-plane words.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   th_wr_en/ch/data         threshold table write ({grp, lane} channel index)
//   in_valid/ready/acc/grp/last  accumulator beat stream
//   out_valid/ready/data/last    packed word stream (out_last closes a pixel)
// Pipeline: S0 table read -> S1 quantize -> S2 pack; a single global stall
// freezes every stage while an output word waits for out_ready.
module qconv_threshold_pack
  import qconv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      th_wr_en,
  input  logic [GRP_W+LANE_W-1:0]   th_wr_ch,
  input  logic [TH_W-1:0]           th_wr_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [UNROLL*ACC_W-1:0]   in_acc,
  input  logic [GRP_W-1:0]          in_grp,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*PACK_W-1:0]       out_data,
  output logic                      out_last
);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic                     s1_valid, s1_last;
  logic [UNROLL*ACC_W-1:0]  s1_acc;
  logic                     s2_valid, s2_last;
  logic [UNROLL-1:0]        s2_lo, s2_hi;

  logic [1:0]        lane_q [UNROLL];
  logic [UNROLL-1:0] q_lo, q_hi;

  for (genvar i = 0; i < UNROLL; i++) begin : g_lane
    qconv_threshold_lane u_lane (
      .clk     (clk),
      .wr_en   (th_wr_en && (th_wr_ch[LANE_W-1:0] == LANE_W'(i))),
      .wr_grp  (th_wr_ch[GRP_W+LANE_W-1:LANE_W]),
      .wr_data (th_wr_data),
      .rd_en   (!stall),
      .rd_grp  (in_grp),
      .x       (s1_acc[i*ACC_W +: ACC_W]),
      .q       (lane_q[i])
    );
  end

  always_comb begin
    q_lo = '0;
    q_hi = '0;
    for (int i = 0; i < UNROLL; i++) begin
      q_lo[i] = lane_q[i][0];
      q_hi[i] = lane_q[i][1];
    end
  end

  // Packer: partial planes accumulate in buf0/buf1; a finished word moves to
  // the output register so the next word can fill at full rate.
  logic [PACK_W-1:0]       buf0, buf1, new0, new1;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W+LANE_W-1:0] shamt;
  logic                    wrap;

  always_comb begin
    shamt = {cnt, {LANE_W{1'b0}}};
    new0  = buf0 | (PACK_W'(s2_lo) << shamt);
    new1  = buf1 | (PACK_W'(s2_hi) << shamt);
    wrap  = (cnt == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      buf0      <= '0;
      buf1      <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s1_acc    <= in_acc;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_lo     <= q_lo;
      s2_hi     <= q_hi;
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (wrap || s2_last) begin
          out_valid <= 1'b1;
          out_data  <= {new1, new0};
          out_last  <= s2_last;
          buf0      <= '0;
          buf1      <= '0;
          cnt       <= '0;
        end else begin
          buf0 <= new0;
          buf1 <= new1;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qconv_threshold_pack.sv
// tb_qconv_threshold_pack: directed bench with a channel-level reference
// model (threshold table as integer arrays, words built bit by bit) and one
// per-cycle compare process for the output stream and handshake rules.
module tb_qconv_threshold_pack;
  import qconv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic th_wr_en;
  logic [GRP_W+LANE_W-1:0] th_wr_ch;
  logic [TH_W-1:0] th_wr_data;
  logic in_valid, in_ready, in_last;
  logic [UNROLL*ACC_W-1:0] in_acc;
  logic [GRP_W-1:0] in_grp;
  logic out_valid, out_ready, out_last;
  logic [2*PACK_W-1:0] out_data;

  always #5 clk = ~clk;

  qconv_threshold_pack dut (
    .clk(clk), .rst(rst),
    .th_wr_en(th_wr_en), .th_wr_ch(th_wr_ch), .th_wr_data(th_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_grp(in_grp), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  int mt0 [0:OC_MAX-1];
  int mt1 [0:OC_MAX-1];
  int mt2 [0:OC_MAX-1];
  int mflag [0:OC_MAX-1];
  logic [PACK_W-1:0] mp0, mp1;
  int mpos = 0;
  logic [2*PACK_W-1:0] exp_data [$];
  bit exp_last [$];

  logic [2*PACK_W-1:0] last_word = '0;
  bit last_last = 1'b0;
  int words_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int model_q(input int ch, input int x);
    int c = 0;
    if (mflag[ch] == 1) begin
      c += (x >= mt0[ch]) ? 1 : 0;
      c += (x >= mt1[ch]) ? 1 : 0;
      c += (x >= mt2[ch]) ? 1 : 0;
    end else if (mflag[ch] == -1) begin
      c += (x <= mt0[ch]) ? 1 : 0;
      c += (x <= mt1[ch]) ? 1 : 0;
      c += (x <= mt2[ch]) ? 1 : 0;
    end else begin
      c = mt0[ch] & 3;
    end
    return c;
  endfunction

  task automatic model_beat(input int grp, input int acc [UNROLL], input bit last);
    int q;
    for (int i = 0; i < UNROLL; i++) begin
      q = model_q(grp * UNROLL + i, acc[i]);
      mp0[mpos * UNROLL + i] = q[0];
      mp1[mpos * UNROLL + i] = q[1];
    end
    mpos++;
    if (mpos == BEATS || last) begin
      exp_data.push_back({mp1, mp0});
      exp_last.push_back(last);
      mp0 = '0;
      mp1 = '0;
      mpos = 0;
    end
  endtask

  task automatic load(input int ch, input int t0, input int t1, input int t2, input int fl);
    mt0[ch] = t0; mt1[ch] = t1; mt2[ch] = t2; mflag[ch] = fl;
    th_wr_en   = 1'b1;
    th_wr_ch   = (GRP_W+LANE_W)'(ch);
    th_wr_data = {ACC_W'(fl), ACC_W'(t2), ACC_W'(t1), ACC_W'(t0)};
    @(posedge clk); #1;
    th_wr_en = 1'b0;
  endtask

  task automatic send(input int grp, input int acc [UNROLL], input bit last);
    bit ok = 1'b0;
    for (int i = 0; i < UNROLL; i++) in_acc[i*ACC_W +: ACC_W] = ACC_W'(acc[i]);
    in_grp   = GRP_W'(grp);
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      model_beat(grp, acc, last);
      @(posedge clk); #1;
    end else begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 300 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_data.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_data.size());
    end
    @(posedge clk); #1;
  endtask

  // Per-cycle checker: handshake rule, hold-while-stalled, word scoreboard.
  logic [2*PACK_W-1:0] prev_data;
  bit prev_hold = 1'b0;
  bit prev_last;
  always @(negedge clk) begin
    logic [2*PACK_W-1:0] ed;
    bit el;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, prev_data);
        check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %h want none", out_data);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          check("word_data", out_data, ed);
          check("word_last", 64'(out_last), 64'(el));
          last_word  = out_data;
          last_last  = out_last;
          words_seen++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a [UNROLL];
    int n;
    int w0;
    bit seen;
    rst = 1'b1; th_wr_en = 1'b0; th_wr_ch = '0; th_wr_data = '0;
    in_valid = 1'b0; in_acc = '0; in_grp = '0; in_last = 1'b0; out_ready = 1'b1;
    mp0 = '0; mp1 = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Increasing thresholds, single in_last beat, latency.
    for (int c = 0; c < 8; c++) load(c, 10, 20, 30, 1);
    a = '{5, 10, 19, 20, 29, 30, 31, -4};
    check("pin_model_inc", 64'(model_q(4, 29)), 64'd2);
    send(0, a, 1'b1);
    idle();
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("latency", 64'(n), 64'd3);
    check("t1_seen", 64'(seen), 64'd1);
    check("t1_plane0", 64'(out_data[7:0]), 64'h66);
    check("t1_plane1", 64'(out_data[PACK_W +: 8]), 64'h78);
    check("t1_upper0", 64'(out_data[PACK_W-1:8]), 64'd0);
    check("t1_upper1", 64'(out_data[2*PACK_W-1:PACK_W+8]), 64'd0);
    check("t1_last", 64'(out_last), 64'd1);
    drain();

    // Decreasing and constant flags on group 1.
    load(8, 10, 20, 30, -1);
    load(9, 3, 0, 0, 0);
    for (int c = 10; c < 16; c++) load(c, 0, 0, 0, 0);
    check("pin_model_dec", 64'(model_q(8, 15)), 64'd2);
    check("pin_model_const", 64'(model_q(9, 123)), 64'd3);
    a = '{15, 123, 0, 0, 0, 0, 0, 0};
    send(1, a, 1'b1);
    idle();
    drain();
    check("t2_plane0", 64'(last_word[7:0]), 64'h02);
    check("t2_plane1", 64'(last_word[PACK_W +: 8]), 64'h03);
    a = '{10, -500, 7, 7, 7, 7, 7, 7};
    send(1, a, 1'b1);
    idle();
    drain();

    // Full word, with and without in_last on the 4th beat.
    for (int c = 0; c < 32; c++) load(c, 0, 0, 0, 1);
    a = '{100, 100, 100, 100, 100, 100, 100, 100};
    for (int b = 0; b < 4; b++) send(b, a, b == 3);
    idle();
    drain();
    check("t3_full", last_word, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_last", 64'(last_last), 64'd1);
    for (int b = 0; b < 4; b++) send(b, a, 1'b0);
    idle();
    drain();
    check("t3_nolast", 64'(last_last), 64'd0);

    // Mixed table for the remaining tests.
    for (int c = 0; c < 32; c++) begin
      if (c % 3 == 0)      load(c, -10, 0, 10, 1);
      else if (c % 3 == 1) load(c, -10, 0, 10, -1);
      else                 load(c, c % 4, 0, 0, 5);
    end

    // Backpressure: 8 beats, out_ready low 10 cycles after the first word.
    w0 = words_seen;
    fork
      begin
        int b8 [UNROLL];
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < UNROLL; i++) b8[i] = ((i * 7 + b * 13) % 41) - 20;
          send(b % 4, b8, 1'b0);
        end
        idle();
      end
      begin
        bit got = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) begin
            got = 1'b1;
            break;
          end
        end
        check("bp_first_word", 64'(got), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_stalled_valid", 64'(out_valid), 64'd1);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_words", 64'(words_seen - w0), 64'd2);

    // Partial word closed by in_last, then a fresh word.
    a = '{50, 50, 50, 50, 50, 50, 50, 50};
    for (int b = 0; b < 3; b++) send(b, a, b == 2);
    idle();
    drain();
    check("t5_top0", 64'(last_word[PACK_W-1:24]), 64'd0);
    check("t5_top1", 64'(last_word[2*PACK_W-1:PACK_W+24]), 64'd0);
    check("t5_last", 64'(last_last), 64'd1);
    send(0, a, 1'b1);
    idle();
    drain();
    check("t5_fresh0", 64'(last_word[PACK_W-1:8]), 64'd0);

    // Reset after two beats of a word.
    a = '{-20, -5, 0, 5, 20, -11, 11, 3};
    send(0, a, 1'b0);
    send(1, a, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mp0 = '0; mp1 = '0; mpos = 0;
    exp_data.delete();
    exp_last.delete();
    @(negedge clk);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(2, a, 1'b0);
    send(3, a, 1'b1);
    idle();
    drain();
    check("t6_hi0", 64'(last_word[PACK_W-1:16]), 64'd0);
    check("t6_hi1", 64'(last_word[2*PACK_W-1:PACK_W+16]), 64'd0);
    check("t6_last", 64'(last_last), 64'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
